// File: rtl/decoder_2to4.sv
// decoder_2to4: registered 2-to-4 one-hot decoder with enable, valid flag and selectable output polarity
module decoder_2to4 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i0,
    input  logic i1,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic valid
);
    logic [3:0] y_d, y_q;
    logic       valid_d, valid_q;
    logic       unused_reset_val;
    assign unused_reset_val = RESET_VAL;
    always_comb begin
        y_d     = (en ? 4'b0001 << {i1, i0} : 4'b0000) ^ {4{ACTIVE_LOW}};
        valid_d = en;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= {4{ACTIVE_LOW}};
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end
    assign {y3, y2, y1, y0} = y_q;
    assign valid            = valid_q;
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: directed and random checks of both output polarities of decoder_2to4
module tb_decoder_2to4;
    logic clk = 1'b0;
    logic rst, en, i0, i1;
    logic hy0, hy1, hy2, hy3, hv;
    logic ly0, ly1, ly2, ly3, lv;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decoder_2to4 #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .i0(i0), .i1(i1),
        .y0(hy0), .y1(hy1), .y2(hy2), .y3(hy3), .valid(hv)
    );

    decoder_2to4 #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .i0(i0), .i1(i1),
        .y0(ly0), .y1(ly1), .y2(ly2), .y3(ly3), .valid(lv)
    );

    task automatic apply(input logic e, input logic [1:0] s);
        @(negedge clk);
        en       = e;
        {i1, i0} = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_y, input logic exp_v);
        tests++;
        assert ({hy3, hy2, hy1, hy0, hv} === {exp_y, exp_v}) else begin
            fails++;
            $error("FAIL %s high: y3..y0,valid got %b required %b", tag, {hy3, hy2, hy1, hy0, hv}, {exp_y, exp_v});
        end
        tests++;
        assert ({ly3, ly2, ly1, ly0, lv} === {~exp_y, exp_v}) else begin
            fails++;
            $error("FAIL %s low: y3..y0,valid got %b required %b", tag, {ly3, ly2, ly1, ly0, lv}, {~exp_y, exp_v});
        end
    endtask

    initial begin
        logic       e;
        logic [1:0] s;
        logic [3:0] exp_y;
        rst = 1'b1;
        en  = 1'b1;
        {i1, i0} = 2'b11;
        #2;
        check("reset_no_edge", 4'b0000, 1'b0);
        @(negedge clk);
        check("reset_held_edge", 4'b0000, 1'b0);
        rst = 1'b0;

        apply(1'b1, 2'b00); check("sweep00", 4'b0001, 1'b1);
        apply(1'b1, 2'b01); check("sweep01", 4'b0010, 1'b1);
        apply(1'b1, 2'b10); check("sweep10", 4'b0100, 1'b1);
        apply(1'b1, 2'b11); check("sweep11", 4'b1000, 1'b1);

        apply(1'b0, 2'b10); check("en_low", 4'b0000, 1'b0);
        apply(1'b1, 2'b10); check("en_back", 4'b0100, 1'b1);

        apply(1'b1, 2'b11); check("pre_reset", 4'b1000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 1'b0);
        {i1, i0} = 2'b01;
        @(posedge clk);
        #1;
        check("reset_over_edge", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_release", 4'b0010, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            e = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            exp_y = e ? (4'b0001 << s) : 4'b0000;
            apply(e, s);
            check("random", exp_y, e);
            tests++;
            assert ($countones({hy3, hy2, hy1, hy0}) == int'(e) && $countones({hy3, hy2, hy1, hy0}) == int'(hv)) else begin
                fails++;
                $error("FAIL onehot: ones got %0d required %0d (valid %b)", $countones({hy3, hy2, hy1, hy0}), e, hv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
